// File: rtl/svnet_pkg.sv
// Shared types and constants for the svnet RAM blocks.
package svnet_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } svnet_ram_reader_state_t;

   localparam int SVNET_RAM_READ_LATENCY = 2;
   localparam int SVNET_RAM_R2R_DELAY    = 2;

   // A one-word RAM still needs a one-bit address port.
   function automatic int svnet_addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/svnet_fifo.sv
// Synchronous FIFO with flop-based storage; output word and count come straight from registers.
module svnet_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       valid,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL      = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == LAST_SLOT) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         assert (!(wr_en && count == FULL));
         if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= bump(wr_ptr);
         end
         if (rd_en) rd_ptr <= bump(rd_ptr);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];
   assign valid   = (count != '0);

endmodule

// File: rtl/svnet_ram_reader.sv
// Burst read initiator: paced, credit-limited single-word RAM reads returned as a
// valid/ready stream with a last marker.
module svnet_ram_reader import svnet_pkg::*; #(
   parameter int DEPTH      = 1,
   parameter int WIDTH      = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int R2R_DELAY  = SVNET_RAM_R2R_DELAY
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               cmd_valid,
   output logic                               cmd_ready,
   input  logic [svnet_addr_width(DEPTH)-1:0] cmd_address,
   input  logic [$clog2(DEPTH):0]             cmd_count,
   output logic                               read,
   output logic [svnet_addr_width(DEPTH)-1:0] read_address,
   input  logic                               read_data_valid,
   input  logic [WIDTH-1:0]                   read_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [WIDTH-1:0]                   out_data,
   output logic                               out_last,
   output logic                               busy
);

   localparam int AW = svnet_addr_width(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int FW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(R2R_DELAY + 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [FW:0]   CREDITS   = (FW + 1)'(FIFO_DEPTH);
   localparam logic [PW-1:0] PACE_LOAD = PW'(R2R_DELAY - 1);

   svnet_ram_reader_state_t state, state_next;

   logic          out_of_reset;
   logic [AW-1:0] addr;
   logic [CW-1:0] issue_cnt;
   logic [CW-1:0] out_cnt;
   logic [PW-1:0] pace;
   logic [FW-1:0] in_flight;
   logic [FW-1:0] fifo_count;
   logic          accept;
   logic          credit_ok;
   logic          rsp_ok;
   logic          pop;

   // RAM data cannot be stalled, so a read is only issued when the FIFO has
   // room for every response still in flight plus this one.
   assign credit_ok    = ({1'b0, fifo_count} + {1'b0, in_flight}) < CREDITS;
   assign read         = (state == ISSUE) && (pace == '0) && credit_ok;
   assign read_address = addr;
   assign cmd_ready    = (state == IDLE) && out_of_reset;
   assign accept       = cmd_valid && cmd_ready;
   assign rsp_ok       = read_data_valid && (in_flight != '0);
   assign pop          = out_valid && out_ready;
   assign out_last     = out_valid && (out_cnt == CW'(1));
   assign busy         = (state != IDLE);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept && cmd_count != '0) state_next = ISSUE;
         ISSUE:   if (read && issue_cnt == CW'(1)) state_next = DRAIN;
         DRAIN:   if (out_cnt == '0 || (pop && out_cnt == CW'(1))) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         out_of_reset <= 1'b0;
         addr         <= '0;
         issue_cnt    <= '0;
         out_cnt      <= '0;
         pace         <= '0;
         in_flight    <= '0;
      end else begin
         assert (!(read_data_valid && in_flight == '0));
         state        <= state_next;
         out_of_reset <= 1'b1;
         if (accept) begin
            addr      <= cmd_address;
            issue_cnt <= cmd_count;
            out_cnt   <= cmd_count;
            pace      <= '0;
         end else begin
            if (read) begin
               addr      <= (addr == LAST_ADDR) ? '0 : addr + AW'(1);
               issue_cnt <= issue_cnt - CW'(1);
               pace      <= PACE_LOAD;
            end else if (pace != '0) begin
               pace <= pace - PW'(1);
            end
            if (pop) out_cnt <= out_cnt - CW'(1);
         end
         case ({read, rsp_ok})
            2'b10:   in_flight <= in_flight + FW'(1);
            2'b01:   in_flight <= in_flight - FW'(1);
            default: ;
         endcase
      end
   end

   svnet_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (rsp_ok),
      .wr_data (read_data),
      .rd_en   (pop),
      .rd_data (out_data),
      .valid   (out_valid),
      .count   (fifo_count)
   );

endmodule

// File: tb/tb_svnet_ram_reader.sv
// Directed bench for svnet_ram_reader: two instances (DEPTH 8 and DEPTH 6) each
// attached to a 2-cycle RAM model preloaded with 0x10+address; stream checked by scoreboard.
module tb_svnet_ram_reader;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] cmd_address;
   logic [3:0] cmd_count;
   logic       out_ready;

   logic         cmd_valid [2];
   logic         cmd_ready [2];
   logic         rd        [2];
   logic [2:0]   rd_addr   [2];
   logic [1:0]   rdv;
   logic [W-1:0] rdata     [2];
   logic         out_valid [2];
   logic [W-1:0] out_data  [2];
   logic         out_last  [2];
   logic         busy      [2];

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int reads [2];
   int hs [2];
   int lasts [2];
   int last_hs_cyc [2];
   int rd_cyc_q [$];
   logic [2:0] rd_addr_q [$];
   logic [8:0] exp_q0 [$];
   logic [8:0] exp_q1 [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   svnet_ram_reader #(.DEPTH(8), .WIDTH(W), .FIFO_DEPTH(4), .R2R_DELAY(2)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_address(cmd_address), .cmd_count(cmd_count),
      .read(rd[0]), .read_address(rd_addr[0]),
      .read_data_valid(rdv[0]), .read_data(rdata[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready),
      .out_data(out_data[0]), .out_last(out_last[0]), .busy(busy[0])
   );

   svnet_ram_reader #(.DEPTH(6), .WIDTH(W), .FIFO_DEPTH(4), .R2R_DELAY(2)) dut6 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_address(cmd_address), .cmd_count(cmd_count),
      .read(rd[1]), .read_address(rd_addr[1]),
      .read_data_valid(rdv[1]), .read_data(rdata[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready),
      .out_data(out_data[1]), .out_last(out_last[1]), .busy(busy[1])
   );

   // Two-stage pipeline models the RAM read latency; word at address a is 0x10+a.
   for (genvar g = 0; g < 2; g++) begin : g_ram
      logic         v1, v2;
      logic [W-1:0] d1, d2;
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v1 <= 1'b0; v2 <= 1'b0; d1 <= '0; d2 <= '0;
         end else begin
            v1 <= rd[g];
            d1 <= 8'h10 + {5'b0, rd_addr[g]};
            v2 <= v1;
            d2 <= d1;
         end
      end
      assign rdv[g]   = v2;
      assign rdata[g] = d2;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard pop and read logging, sampled mid-cycle.
   always @(negedge clk) begin
      logic [8:0] e;
      int         qsize;
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            if (rd[i]) begin
               reads[i]++;
               if (i == 1) begin
                  rd_cyc_q.push_back(cyc);
                  rd_addr_q.push_back(rd_addr[1]);
               end
            end
            if (out_valid[i] && out_ready) begin
               hs[i]++;
               if (out_last[i]) begin
                  lasts[i]++;
                  last_hs_cyc[i] = cyc;
               end
               qsize = (i == 0) ? exp_q0.size() : exp_q1.size();
               check("sb_word_expected", 32'(qsize != 0), 1);
               if (qsize != 0) begin
                  e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                  check("sb_data", 32'(out_data[i]), 32'(e[7:0]));
                  check("sb_last", 32'(out_last[i]), 32'(e[8]));
               end
            end
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int i, input int a, input int c, input int depth);
      logic [8:0] w;
      for (int k = 0; k < c; k++) begin
         w = {(k == c - 1), 8'(8'h10 + (a + k) % depth)};
         if (i == 0) exp_q0.push_back(w);
         else        exp_q1.push_back(w);
      end
   endtask

   task automatic issue_cmd(input int i, input int a, input int c, output int acc);
      int n = 0;
      cmd_address  = 3'(a);
      cmd_count    = 4'(c);
      cmd_valid[i] = 1'b1;
      while (!cmd_ready[i] && n < 50) begin
         step();
         n++;
      end
      check("cmd_accept", 32'(cmd_ready[i]), 1);
      acc = cyc;
      push_exp(i, a, c, (i == 0) ? 8 : 6);
      step();
      cmd_valid[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i, input int budget);
      int n = 0;
      while (busy[i] && n < budget) begin
         step();
         n++;
      end
      check("return_to_idle", 32'(busy[i]), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int acc, acc2, r0, h0, l0, n;
      int exp_addr [4] = '{4, 5, 0, 1};

      cmd_valid[0] = 1'b0;
      cmd_valid[1] = 1'b0;
      cmd_address  = '0;
      cmd_count    = '0;
      out_ready    = 1'b1;
      rst_n        = 1'b0;
      step(2);

      // Reset values while reset is held.
      check("rst_cmd_ready", 32'(cmd_ready[0]), 0);
      check("rst_read", 32'(rd[0]), 0);
      check("rst_read_address", 32'(rd_addr[0]), 0);
      check("rst_out_valid", 32'(out_valid[0]), 0);
      check("rst_out_data", 32'(out_data[0]), 0);
      check("rst_out_last", 32'(out_last[0]), 0);
      check("rst_busy", 32'(busy[0]), 0);
      rst_n = 1'b1;
      step();
      check("ready_after_release", 32'(cmd_ready[0]), 1);

      // Single-word burst: exact latency of read, data and idle.
      cmd_address  = 3'd2;
      cmd_count    = 4'd1;
      cmd_valid[0] = 1'b1;
      check("t1_cmd_ready", 32'(cmd_ready[0]), 1);
      push_exp(0, 2, 1, 8);
      step();
      cmd_valid[0] = 1'b0;
      check("t1_read", 32'(rd[0]), 1);
      check("t1_read_address", 32'(rd_addr[0]), 2);
      check("t1_busy", 32'(busy[0]), 1);
      step();
      check("t1_single_read", 32'(rd[0]), 0);
      step();
      check("t1_no_early_out", 32'(out_valid[0]), 0);
      step();
      check("t1_out_valid", 32'(out_valid[0]), 1);
      check("t1_out_data", 32'(out_data[0]), 32'h12);
      check("t1_out_last", 32'(out_last[0]), 1);
      step();
      check("t1_busy_low", 32'(busy[0]), 0);
      check("t1_out_valid_low", 32'(out_valid[0]), 0);

      // Address wrap on a non-power-of-two RAM.
      rd_cyc_q.delete();
      rd_addr_q.delete();
      issue_cmd(1, 4, 4, acc);
      wait_idle(1, 100);
      check("wrap_read_count", 32'(rd_addr_q.size()), 4);
      for (int k = 0; k < 4 && k < rd_addr_q.size(); k++) begin
         check("wrap_read_address", 32'(rd_addr_q[k]), 32'(exp_addr[k]));
         if (k == 0) check("wrap_first_read_cycle", 32'(rd_cyc_q[0]), 32'(acc + 1));
         else        check("wrap_read_spacing", 32'(rd_cyc_q[k] - rd_cyc_q[k-1]), 2);
      end
      check("wrap_last_count", 32'(lasts[1]), 1);
      check("wrap_sb_empty", 32'(exp_q1.size()), 0);

      // Back-pressure: credits cap outstanding reads at the FIFO depth.
      out_ready = 1'b0;
      r0 = reads[0];
      issue_cmd(0, 0, 8, acc);
      step(20);
      check("stall_reads", 32'(reads[0] - r0), 4);
      check("stall_out_valid", 32'(out_valid[0]), 1);
      check("stall_out_data_held", 32'(out_data[0]), 32'h10);
      check("stall_busy", 32'(busy[0]), 1);
      h0 = hs[0];
      out_ready = 1'b1;
      wait_idle(0, 200);
      check("stall_words", 32'(hs[0] - h0), 8);
      check("stall_reads_total", 32'(reads[0] - r0), 8);
      check("stall_sb_empty", 32'(exp_q0.size()), 0);

      // Zero-length command is a no-op.
      r0 = reads[0];
      cmd_address  = 3'd3;
      cmd_count    = 4'd0;
      cmd_valid[0] = 1'b1;
      step();
      cmd_valid[0] = 1'b0;
      check("zero_busy", 32'(busy[0]), 0);
      step(4);
      check("zero_cmd_ready", 32'(cmd_ready[0]), 1);
      check("zero_out_valid", 32'(out_valid[0]), 0);
      check("zero_reads", 32'(reads[0] - r0), 0);

      // Asynchronous reset in the middle of a burst.
      r0 = reads[0];
      issue_cmd(0, 0, 8, acc);
      n = 0;
      while ((reads[0] - r0) < 3 && n < 50) begin
         step();
         n++;
      end
      check("mid_reads_before_reset", 32'(reads[0] - r0), 3);
      rst_n = 1'b0;
      #1;
      check("mid_rst_cmd_ready", 32'(cmd_ready[0]), 0);
      check("mid_rst_read", 32'(rd[0]), 0);
      check("mid_rst_read_address", 32'(rd_addr[0]), 0);
      check("mid_rst_out_valid", 32'(out_valid[0]), 0);
      check("mid_rst_out_data", 32'(out_data[0]), 0);
      check("mid_rst_out_last", 32'(out_last[0]), 0);
      check("mid_rst_busy", 32'(busy[0]), 0);
      exp_q0.delete();
      step();
      rst_n = 1'b1;
      step();
      h0 = hs[0];
      issue_cmd(0, 0, 2, acc);
      wait_idle(0, 100);
      check("post_reset_words", 32'(hs[0] - h0), 2);
      check("post_reset_sb_empty", 32'(exp_q0.size()), 0);

      // Back-to-back commands.
      h0 = hs[0];
      l0 = lasts[0];
      issue_cmd(0, 0, 3, acc);
      issue_cmd(0, 5, 2, acc2);
      check("b2b_accept_cycle", 32'(acc2), 32'(last_hs_cyc[0] + 1));
      check("b2b_first_read", 32'(rd[0]), 1);
      wait_idle(0, 100);
      check("b2b_words", 32'(hs[0] - h0), 5);
      check("b2b_last_pulses", 32'(lasts[0] - l0), 2);
      check("b2b_sb_empty", 32'(exp_q0.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
